// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC, arbitrates redirects, handshakes with IF.
// Optional MIPS branch delay slot behaviour via `define BRANCH_DELAY_SLOT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        if_ready,
  input  logic        exc_valid,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush_if
);

`ifdef BRANCH_DELAY_SLOT_EN
  typedef enum logic [1:0] {BOOT, RUN, DSLOT} state_e;
  logic [31:0] pend_q, pend_d;
`else
  typedef enum logic {BOOT, RUN} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        fire;

  assign pc_valid = (state_q != BOOT);
  assign fire     = pc_valid & if_ready & ~stall;
  assign pc       = pc_q;
  assign flush_if = flush_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_d  = pend_q;
`endif
    // Priority chain: exception > eret > branch
    if (exc_valid) begin
      pc_d    = EXC_VEC & ~32'd3;
      flush_d = 1'b1;
      state_d = RUN;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_d  = '0;
`endif
    end else if (eret_valid) begin
      pc_d    = epc & ~32'd3;
      flush_d = 1'b1;
      state_d = RUN;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_d  = '0;
`endif
    end else begin
`ifdef BRANCH_DELAY_SLOT_EN
      unique case (state_q)
        BOOT: begin
          if (br_valid) pc_d = br_target & ~32'd3;
          state_d = RUN;
        end
        RUN: begin
          if (br_valid && fire) begin
            pc_d = br_target & ~32'd3;
          end else if (br_valid) begin
            pend_d  = br_target & ~32'd3;
            state_d = DSLOT;
          end else if (fire) begin
            pc_d = pc_q + 32'd4;
          end
        end
        DSLOT: begin
          if (fire) begin
            pc_d    = pend_q;
            state_d = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
`else
      if (br_valid) begin
        pc_d    = br_target & ~32'd3;
        flush_d = 1'b1;
        state_d = RUN;
      end else if (state_q == BOOT) begin
        state_d = RUN;
      end else if (fire) begin
        pc_d = pc_q + 32'd4;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      flush_q <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_q  <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Covers reset, advance, stall, redirects, priority, wrap and async reset.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        if_ready;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;
  logic        br_valid;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush_if;

  int n_chk  = 0;
  int n_fail = 0;

  pc_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .if_ready   (if_ready),
    .exc_valid  (exc_valid),
    .eret_valid (eret_valid),
    .epc        (epc),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .flush_if   (flush_if)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] epc_x,
                         input logic ev, input logic ef);
    chk({tag, ".pc"}, pc, epc_x);
    chk({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, ev});
    chk({tag, ".flush"}, {31'd0, flush_if}, {31'd0, ef});
  endtask

  initial begin
    reset      = 1'b0;
    stall      = 1'b0;
    if_ready   = 1'b1;
    exc_valid  = 1'b0;
    eret_valid = 1'b0;
    epc        = '0;
    br_valid   = 1'b0;
    br_target  = '0;

    repeat (3) step();
    chk_out("rst", 32'h3000, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk_out("boot", 32'h3000, 1'b0, 1'b0);
    step(); chk_out("run0", 32'h3000, 1'b1, 1'b0);
    step(); chk_out("seq1", 32'h3004, 1'b1, 1'b0);
    step(); chk_out("seq2", 32'h3008, 1'b1, 1'b0);

    stall = 1'b1;
    step(); chk_out("stall1", 32'h3008, 1'b1, 1'b0);
    step(); chk_out("stall2", 32'h3008, 1'b1, 1'b0);
    stall = 1'b0;
    step(); chk_out("unstall", 32'h300C, 1'b1, 1'b0);

`ifdef BRANCH_DELAY_SLOT_EN
    step(); chk_out("seq3", 32'h3010, 1'b1, 1'b0);
    if_ready  = 1'b0;
    br_valid  = 1'b1;
    br_target = 32'h3100;
    step(); chk_out("ds_hold", 32'h3010, 1'b1, 1'b0);
    br_target = 32'h3300;
    step(); chk_out("ds_ign", 32'h3010, 1'b1, 1'b0);
    br_valid = 1'b0;
    if_ready = 1'b1;
    step(); chk_out("ds_take", 32'h3100, 1'b1, 1'b0);
    br_valid  = 1'b1;
    br_target = 32'h3200;
    step(); chk_out("br_fire", 32'h3200, 1'b1, 1'b0);
    br_valid = 1'b0;
    step(); chk_out("br_seq", 32'h3204, 1'b1, 1'b0);
`else
    br_valid  = 1'b1;
    br_target = 32'h3100;
    step(); chk_out("br", 32'h3100, 1'b1, 1'b1);
    br_valid = 1'b0;
    step(); chk_out("br_seq", 32'h3104, 1'b1, 1'b0);
`endif

    exc_valid  = 1'b1;
    eret_valid = 1'b1;
    epc        = 32'h5000;
    br_valid   = 1'b1;
    br_target  = 32'h6000;
    step(); chk_out("exc_pri", 32'h4180, 1'b1, 1'b1);
    exc_valid  = 1'b0;
    eret_valid = 1'b0;
    br_valid   = 1'b0;
    step(); chk_out("exc_seq", 32'h4184, 1'b1, 1'b0);

    eret_valid = 1'b1;
    epc        = 32'h1237;
    stall      = 1'b1;
    step(); chk_out("eret_stall", 32'h1234, 1'b1, 1'b1);
    eret_valid = 1'b0;
    stall      = 1'b0;
    step(); chk_out("eret_seq", 32'h1238, 1'b1, 1'b0);

    eret_valid = 1'b1;
    epc        = 32'h2000;
    br_valid   = 1'b1;
    br_target  = 32'h6000;
    step(); chk_out("eret_pri", 32'h2000, 1'b1, 1'b1);
    br_valid = 1'b0;
    epc      = 32'hFFFF_FFFC;
    step(); chk_out("wrap0", 32'hFFFF_FFFC, 1'b1, 1'b1);
    eret_valid = 1'b0;
    step(); chk_out("wrap1", 32'h0000_0000, 1'b1, 1'b0);
    if_ready = 1'b0;
    step(); chk_out("nordy", 32'h0000_0000, 1'b1, 1'b0);

`ifdef BRANCH_DELAY_SLOT_EN
    br_valid  = 1'b1;
    br_target = 32'h5000;
    step(); chk_out("ds_enter", 32'h0000_0000, 1'b1, 1'b0);
    br_valid = 1'b0;
`endif
    reset = 1'b0;
    #1;
    chk_out("async_rst", 32'h3000, 1'b0, 1'b0);
    step();
    if_ready = 1'b1;
    reset    = 1'b1;
    #1;
    chk_out("boot2", 32'h3000, 1'b0, 1'b0);
    exc_valid = 1'b1;
    step(); chk_out("exc_boot", 32'h4180, 1'b1, 1'b1);
    exc_valid = 1'b0;
    step(); chk_out("exc_boot_seq", 32'h4184, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
